// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - (16*WORDS)-bit adder sequencer time-sharing one 16-bit carry-select slice
// Optional subtract mode (sub input, result a-b) enabled by defining MP_ADD_SEQ_SUB_EN.

module mp_add_seq_csa16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    // Upper byte is precomputed for both carry values; the low byte's carry picks one.
    assign lo  = {1'b0, x[7:0]} + {1'b0, y[7:0]} + {8'b0, ci};
    assign hi0 = {1'b0, x[15:8]} + {1'b0, y[15:8]};
    assign hi1 = {1'b0, x[15:8]} + {1'b0, y[15:8]} + 9'd1;

    assign s[7:0]         = lo[7:0];
    assign {co, s[15:8]}  = lo[8] ? hi1 : hi0;
endmodule

module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 c_in,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [16*WORDS-1:0]  sum,
    output logic                 c_out,
    output logic                 busy
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    b_load;
    logic            carry_load;
    logic [15:0]     a_slice;
    logic [15:0]     b_slice;
    logic [15:0]     add_sum;
    logic            add_co;

`ifdef MP_ADD_SEQ_SUB_EN
    // Subtraction as a + ~b + 1; inverting at latch time keeps the run loop identical.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = b;
    assign carry_load = c_in;
`endif

    assign a_slice = a_reg[{idx, 4'b0000} +: 16];
    assign b_slice = b_reg[{idx, 4'b0000} +: 16];

    mp_add_seq_csa16 u_csa (
        .x  (a_slice),
        .y  (b_slice),
        .ci (carry),
        .s  (add_sum),
        .co (add_co)
    );

    assign start_ready = (state == S_IDLE);
    assign res_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_valid) state_next = S_RUN;
            S_RUN:   if (idx == LAST) state_next = S_DONE;
            S_DONE:  if (res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        a_reg <= a;
                        b_reg <= b_load;
                        carry <= carry_load;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    sum[{idx, 4'b0000} +: 16] <= add_sum;
                    carry <= add_co;
                    if (idx == LAST) begin
                        c_out <= add_co;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision adder sequencer: performs one (16*WORDS)-bit addition by time-sharing a single 16-bit carry-select adder instance (CSA), one 16-bit slice per cycle, LSB slice first.
- Carry is registered between slices.
- Sits between a requester and a consumer using valid/ready handshakes on both sides.
- Used wherever wide sums are needed without replicating adder hardware.

Parameters:
WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 1..16

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; one clock; reset is synchronous and active-low
start_valid  input  1  requester presents operands
start_ready  output  1  sequencer can accept operands (IDLE only)
a  input  W  operand A, sampled on start handshake
b  input  W  operand B, sampled on start handshake
c_in  input  1  carry into slice 0, sampled on start handshake
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
sum  output  W  registered result
c_out  output  1  carry out of the most-significant slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, slice index=0, carry reg=0, sum=0, c_out=0, res_valid=0, busy=0. start_ready=1 from the first cycle after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch a, b; carry reg<=c_in; index<=0; go to RUN.
- RUN:
  - start_ready=0, busy=1.
  - Adder inputs: slice[index] of latched a and b, with c_in = carry reg.
  - Each cycle: sum[16*index+:16] <= adder sum; carry reg <= adder c_out; index++.
  - When index==WORDS-1: c_out <= adder c_out; go to DONE.
- DONE:
  - res_valid=1; sum and c_out held stable.
  - On res_ready: go to IDLE and clear res_valid.
- Latency: res_valid is first high exactly WORDS cycles after the start-handshake edge. Throughput is one operation per WORDS+2 cycles with res_ready tied high.
- WORDS=1: RUN lasts one cycle.
- No start is accepted in DONE, even when res_ready is high in the same cycle; start_ready rises the cycle after return to IDLE.
- start_valid, a, b and c_in are ignored outside IDLE. Operands may change freely after acceptance.
- Slice bits not yet written in RUN hold their values from the previous operation. sum is defined only while res_valid=1.
- sum and c_out hold after return to IDLE until the next RUN overwrites them.
- Reset mid-RUN or mid-DONE: the operation is aborted, the result is discarded, and all state takes reset values. No res_valid pulse is produced.
- Index register width: clog2(WORDS), minimum 1 bit. The index never exceeds WORDS-1.

Optional Feature:
- Macro: MP_ADD_SEQ_SUB_EN.
- Defined:
  - Extra 1-bit input port sub, sampled on start handshake.
  - When the latched sub=1: b slices are inverted before the adder, and the carry reg initialises to 1 (c_in ignored). Result is a-b.
  - c_out=1 means no borrow.
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port; behaviour and logic identical to base addition only.

Test Plan:
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, c_in=0, res_ready=1 -> res_valid 4 cycles after accept, sum=0x0, c_out=1.
- a=0x0001_0002_0003_0004, b=0x0010_0020_0030_0040, c_in=1 -> sum=0x0011_0022_0033_0045, c_out=0.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid stays 1, sum/c_out stable, start_ready=0. Raise res_ready -> next cycle res_valid=0, start_ready=1.
- start_valid held high during RUN with a, b changed every cycle -> only the first operands are used; exactly one result per handshake.
- rst_n=0 for one cycle after 2 RUN cycles -> next cycle state IDLE: start_ready=1, res_valid=0, busy=0, sum=0; no stale result appears.
- MP_ADD_SEQ_SUB_EN defined, sub=1, a=0x5, b=0x7 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0. With a=0x7, b=0x5 -> sum=0x2, c_out=1.
